// File: rtl/gps_ack_search.sv
// GPS L1 C/A acquisition engine: captures 2^SAMPLE_BITS 1-bit I/Q samples, sweeps
// code phase x Doppler bin x PRN with NUM_CH complex correlators, streams one peak per PRN.
//
// state   | meaning
// IDLE    | waiting for ack_start
// CAPTURE | storing one I/Q pair per synchronised adc_clk rising edge
// LOAD    | seed LFSRs for the current phase, clear NCOs/accumulators, set omega
// CORR    | one sample per cycle into every channel's I/Q accumulators
// UPDATE  | fold correlation magnitudes into per-channel peaks, advance phase/bin
// REPORT  | hand out NUM_CH results over valid/ready
// DONE    | one-cycle done pulse
module gps_ack_search #(
  parameter int                 SAMPLE_BITS    = 12,
  parameter int                 NUM_CH         = 4,
  parameter int                 NUM_PHASES     = 1023,
  parameter int                 CODE_NCO_OMEGA = 131,
  parameter int                 NCO_BITS       = 9,
  parameter int                 NUM_DOPPLER    = 8,
  parameter logic signed [15:0] DOPPLER_START  = -16'sd1000,
  parameter logic signed [15:0] DOPPLER_STEP   = 16'sd250
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ack_start,
  input  logic                   abort,
  input  logic                   adc_clk,
  input  logic                   i_sample,
  input  logic                   q_sample,
  output logic                   busy,
  output logic                   done,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [5:0]             res_prn,
  output logic [9:0]             res_code_phase,
  output logic [7:0]             res_bin,
  output logic [SAMPLE_BITS+2:0] res_mag
);

  localparam int N        = 1 << SAMPLE_BITS;
  localparam int AW       = SAMPLE_BITS + 2;
  localparam int MW       = SAMPLE_BITS + 3;
  localparam int NUM_PASS = 32 / NUM_CH;
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [NCO_BITS:0]    CODE_INC = (NCO_BITS + 1)'(CODE_NCO_OMEGA);
  localparam logic signed [AW-1:0] ONE      = 1;
  localparam logic [3:0]           LO_I_TBL = 4'b1100;
  localparam logic [3:0]           LO_Q_TBL = 4'b0110;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CAPTURE = 3'd1;
  localparam logic [2:0] S_LOAD    = 3'd2;
  localparam logic [2:0] S_CORR    = 3'd3;
  localparam logic [2:0] S_UPDATE  = 3'd4;
  localparam logic [2:0] S_REPORT  = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

  function automatic logic [7:0] g2_taps(input int prn);
    case (prn)
      1:  return {4'd2, 4'd6};   2:  return {4'd3, 4'd7};
      3:  return {4'd4, 4'd8};   4:  return {4'd5, 4'd9};
      5:  return {4'd1, 4'd9};   6:  return {4'd2, 4'd10};
      7:  return {4'd1, 4'd8};   8:  return {4'd2, 4'd9};
      9:  return {4'd3, 4'd10};  10: return {4'd2, 4'd3};
      11: return {4'd3, 4'd4};   12: return {4'd5, 4'd6};
      13: return {4'd6, 4'd7};   14: return {4'd7, 4'd8};
      15: return {4'd8, 4'd9};   16: return {4'd9, 4'd10};
      17: return {4'd1, 4'd4};   18: return {4'd2, 4'd5};
      19: return {4'd3, 4'd6};   20: return {4'd4, 4'd7};
      21: return {4'd5, 4'd8};   22: return {4'd6, 4'd9};
      23: return {4'd1, 4'd3};   24: return {4'd4, 4'd6};
      25: return {4'd5, 4'd7};   26: return {4'd6, 4'd8};
      27: return {4'd7, 4'd9};   28: return {4'd8, 4'd10};
      29: return {4'd1, 4'd6};   30: return {4'd2, 4'd7};
      31: return {4'd3, 4'd8};   32: return {4'd4, 4'd9};
      default: return {4'd2, 4'd6};
    endcase
  endfunction

  function automatic logic [10:1] g1_shift(input logic [10:1] g);
    return {g[9:1], g[3] ^ g[10]};
  endfunction

  function automatic logic [10:1] g2_shift(input logic [10:1] g);
    return {g[9:1], g[2] ^ g[3] ^ g[6] ^ g[8] ^ g[9] ^ g[10]};
  endfunction

  logic [2:0]             state;
  logic                   adc_s1, adc_s2, adc_s3, adc_rise;
  logic [SAMPLE_BITS-1:0] cnt;
  logic [N-1:0]           mem_i, mem_q;
  logic [9:0]             phase_cnt;
  logic [7:0]             bin_cnt;
  logic [5:0]             pass_cnt;
  logic [CH_W-1:0]        rep_idx;
  logic [10:1]            g1, g2, g1_base, g2_base;
  logic [NCO_BITS-1:0]    nco;
  logic [NCO_BITS:0]      nco_sum;
  logic [15:0]            cphase, omega, omega_nxt;
  logic                   s_i, s_q, lo_i, lo_q;
  logic [7:0]             taps;
  logic [NUM_CH-1:0]      chip;
  logic [AW-1:0]          abs_i, abs_q;
  logic [MW-1:0]          mag        [NUM_CH];
  logic signed [AW-1:0]   acc_i      [NUM_CH];
  logic signed [AW-1:0]   acc_q      [NUM_CH];
  logic [MW-1:0]          peak_mag   [NUM_CH];
  logic [9:0]             peak_phase [NUM_CH];
  logic [7:0]             peak_bin   [NUM_CH];

  assign adc_rise  = adc_s2 & ~adc_s3;
  assign nco_sum   = {1'b0, nco} + CODE_INC;
  assign omega_nxt = DOPPLER_START + 16'(bin_cnt) * DOPPLER_STEP;
  assign s_i       = mem_i[cnt];
  assign s_q       = mem_q[cnt];
  assign lo_i      = LO_I_TBL[cphase[15:14]];
  assign lo_q      = LO_Q_TBL[cphase[15:14]];

  always_comb begin
    taps = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      taps    = g2_taps(int'(pass_cnt) * NUM_CH + k + 1);
      chip[k] = g1[10] ^ g2[taps[7:4]] ^ g2[taps[3:0]];
    end
  end

  always_comb begin
    abs_i = '0;
    abs_q = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      abs_i  = acc_i[k][AW-1] ? -acc_i[k] : acc_i[k];
      abs_q  = acc_q[k][AW-1] ? -acc_q[k] : acc_q[k];
      mag[k] = {1'b0, abs_i} + {1'b0, abs_q};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      adc_s1 <= 1'b0;
      adc_s2 <= 1'b0;
      adc_s3 <= 1'b0;
    end else begin
      adc_s1 <= adc_clk;
      adc_s2 <= adc_s1;
      adc_s3 <= adc_s2;
    end
  end

  // Sample store needs no reset: it is fully rewritten before every sweep.
  always_ff @(posedge clk) begin
    if (state == S_CAPTURE && adc_rise && !abort) begin
      mem_i[cnt] <= i_sample;
      mem_q[cnt] <= q_sample;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      phase_cnt <= '0;
      bin_cnt   <= '0;
      pass_cnt  <= '0;
      rep_idx   <= '0;
      g1        <= '1;
      g2        <= '1;
      g1_base   <= '1;
      g2_base   <= '1;
      nco       <= '0;
      cphase    <= '0;
      omega     <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        acc_i[k]      <= '0;
        acc_q[k]      <= '0;
        peak_mag[k]   <= '0;
        peak_phase[k] <= '0;
        peak_bin[k]   <= '0;
      end
    end else if (abort) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (ack_start) begin
          state <= S_CAPTURE;
          cnt   <= '0;
        end
        S_CAPTURE: if (adc_rise) begin
          if (&cnt) begin
            state     <= S_LOAD;
            cnt       <= '0;
            phase_cnt <= '0;
            bin_cnt   <= '0;
            pass_cnt  <= '0;
            g1_base   <= '1;
            g2_base   <= '1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_LOAD: begin
          g1     <= g1_base;
          g2     <= g2_base;
          nco    <= '0;
          cphase <= '0;
          omega  <= omega_nxt;
          cnt    <= '0;
          for (int k = 0; k < NUM_CH; k++) begin
            acc_i[k] <= '0;
            acc_q[k] <= '0;
            if (phase_cnt == '0 && bin_cnt == '0) begin
              peak_mag[k]   <= '0;
              peak_phase[k] <= '0;
              peak_bin[k]   <= '0;
            end
          end
          state <= S_CORR;
        end
        S_CORR: begin
          for (int k = 0; k < NUM_CH; k++) begin
            acc_i[k] <= (s_i ^ lo_i ^ chip[k]) ? acc_i[k] - ONE : acc_i[k] + ONE;
            acc_q[k] <= (s_q ^ lo_q ^ chip[k]) ? acc_q[k] - ONE : acc_q[k] + ONE;
          end
          nco    <= nco_sum[NCO_BITS-1:0];
          cphase <= cphase + omega;
          if (nco_sum[NCO_BITS]) begin
            g1 <= g1_shift(g1);
            g2 <= g2_shift(g2);
          end
          cnt <= cnt + 1'b1;
          if (&cnt) state <= S_UPDATE;
        end
        S_UPDATE: begin
          for (int k = 0; k < NUM_CH; k++) begin
            if (mag[k] > peak_mag[k]) begin
              peak_mag[k]   <= mag[k];
              peak_phase[k] <= phase_cnt;
              peak_bin[k]   <= bin_cnt;
            end
          end
          // Base LFSR tracks the start state of phase_cnt one step at a time.
          if (phase_cnt == 10'(NUM_PHASES - 1)) begin
            phase_cnt <= '0;
            g1_base   <= '1;
            g2_base   <= '1;
            if (bin_cnt == 8'(NUM_DOPPLER - 1)) begin
              bin_cnt <= '0;
              rep_idx <= '0;
              state   <= S_REPORT;
            end else begin
              bin_cnt <= bin_cnt + 1'b1;
              state   <= S_LOAD;
            end
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
            g1_base   <= g1_shift(g1_base);
            g2_base   <= g2_shift(g2_base);
            state     <= S_LOAD;
          end
        end
        S_REPORT: if (res_ready) begin
          if (rep_idx == CH_W'(NUM_CH - 1)) begin
            rep_idx <= '0;
            if (pass_cnt == 6'(NUM_PASS - 1)) begin
              state <= S_DONE;
            end else begin
              pass_cnt <= pass_cnt + 1'b1;
              state    <= S_LOAD;
            end
          end else begin
            rep_idx <= rep_idx + 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy           = (state != S_IDLE) && (state != S_DONE);
    done           = state == S_DONE;
    res_valid      = state == S_REPORT;
    res_prn        = '0;
    res_code_phase = '0;
    res_bin        = '0;
    res_mag        = '0;
    if (res_valid) begin
      res_prn        = 6'(int'(pass_cnt) * NUM_CH + int'(rep_idx) + 1);
      res_code_phase = peak_phase[rep_idx];
      res_bin        = peak_bin[rep_idx];
      res_mag        = peak_mag[rep_idx];
    end
  end

endmodule
